// File: rtl/mcs_io_gpio_if.sv
// ============================================================================
// mcs_io_gpio_if : MicroBlaze MCS IO bus signal bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcs_io_gpio_if;
    logic        IO_Addr_Strobe;
    logic        IO_Read_Strobe;
    logic        IO_Write_Strobe;
    logic [31:0] IO_Address;
    logic [3:0]  IO_Byte_Enable;
    logic [31:0] IO_Write_Data;
    logic [31:0] IO_Read_Data;
    logic        IO_Ready;

    modport master (
        output IO_Addr_Strobe,
        output IO_Read_Strobe,
        output IO_Write_Strobe,
        output IO_Address,
        output IO_Byte_Enable,
        output IO_Write_Data,
        input  IO_Read_Data,
        input  IO_Ready
    );

    modport slave (
        input  IO_Addr_Strobe,
        input  IO_Read_Strobe,
        input  IO_Write_Strobe,
        input  IO_Address,
        input  IO_Byte_Enable,
        input  IO_Write_Data,
        output IO_Read_Data,
        output IO_Ready
    );
endinterface

`default_nettype wire

// File: rtl/mcs_io_gpio.sv
// ============================================================================
// mcs_io_gpio : MCS IO-bus GPIO slave (set/clear outputs, debounced inputs, irq)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mcs_io_gpio #(
    parameter logic [31:0]      BASE_ADDR  = 32'hC000_0000,
    parameter int               OUT_W      = 8,
    parameter int               IN_W       = 8,
    parameter int               DEB_CYCLES = 1000,
    parameter logic [OUT_W-1:0] OUT_RST    = '0
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    mcs_io_gpio_if.slave          bus,
    output logic [OUT_W-1:0]      gpo,
    input  wire logic [IN_W-1:0]  gpi,
    output logic                  irq
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [5:0] OFS_DATA = 6'h00;
    localparam logic [5:0] OFS_SET  = 6'h01;
    localparam logic [5:0] OFS_CLR  = 6'h02;
    localparam logic [5:0] OFS_IN   = 6'h03;
    localparam logic [5:0] OFS_FLAG = 6'h04;
    localparam logic [5:0] OFS_IEN  = 6'h05;

    logic             hit;
    logic             wr_en;
    logic [5:0]       offs;
    logic [31:0]      be_mask;
    logic [31:0]      wdm;
    logic             unused_bits;

    logic             ready_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [IN_W-1:0]  sync1_q, sync2_q, deb_q, chg;
    logic [IN_W-1:0]  flag_q, flag_d;
    logic [IN_W-1:0]  ien_q, ien_d;
    logic             irq_q;

    assign hit     = bus.IO_Addr_Strobe && (bus.IO_Address[31:8] == BASE_ADDR[31:8]);
    assign wr_en   = hit && bus.IO_Write_Strobe;
    assign offs    = bus.IO_Address[7:2];
    assign be_mask = {{8{bus.IO_Byte_Enable[3]}}, {8{bus.IO_Byte_Enable[2]}},
                      {8{bus.IO_Byte_Enable[1]}}, {8{bus.IO_Byte_Enable[0]}}};
    assign wdm     = bus.IO_Write_Data & be_mask;

    // Bits beyond the channel widths and the byte-offset address bits carry no meaning here.
    assign unused_bits = ^{bus.IO_Address[1:0], wdm, be_mask};

    // Per-input debounce: a change is accepted only after DEB_CYCLES consecutive differing samples.
    for (genvar i = 0; i < IN_W; i++) begin : g_in
        logic [CNT_W-1:0] cnt_q;
        logic             differ;

        assign differ = sync2_q[i] != deb_q[i];
        assign chg[i] = differ && (cnt_q == CNT_LAST);

        always_ff @(posedge Clk) begin
            if (!Reset) begin
                cnt_q <= '0;
            end else if (!differ || chg[i]) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_d  = out_q;
        ien_d  = ien_q;
        flag_d = flag_q;
        if (wr_en) begin
            case (offs)
                OFS_DATA: out_d  = (out_q & ~be_mask[OUT_W-1:0]) | wdm[OUT_W-1:0];
                OFS_SET:  out_d  = out_q | wdm[OUT_W-1:0];
                OFS_CLR:  out_d  = out_q & ~wdm[OUT_W-1:0];
                OFS_FLAG: flag_d = flag_q & ~wdm[IN_W-1:0];
                OFS_IEN:  ien_d  = (ien_q & ~be_mask[IN_W-1:0]) | wdm[IN_W-1:0];
                default:  ;
            endcase
        end
        // A new debounced edge overrides a same-cycle clear.
        flag_d = flag_d | chg;
    end

    always_comb begin
        rdata_d = '0;
        if (hit && bus.IO_Read_Strobe) begin
            case (offs)
                OFS_DATA: rdata_d[OUT_W-1:0] = out_q;
                OFS_IN:   rdata_d[IN_W-1:0]  = deb_q;
                OFS_FLAG: rdata_d[IN_W-1:0]  = flag_q;
                OFS_IEN:  rdata_d[IN_W-1:0]  = ien_q;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            out_q   <= OUT_RST;
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            flag_q  <= '0;
            ien_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            ready_q <= hit;
            rdata_q <= rdata_d;
            out_q   <= out_d;
            sync1_q <= gpi;
            sync2_q <= sync1_q;
            deb_q   <= deb_q ^ chg;
            flag_q  <= flag_d;
            ien_q   <= ien_d;
            irq_q   <= |(flag_q & ien_q);
        end
    end

    assign bus.IO_Ready     = ready_q;
    assign bus.IO_Read_Data = rdata_q;
    assign gpo              = out_q;
    assign irq              = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_mcs_io_gpio.sv
// ============================================================================
// tb_mcs_io_gpio : directed + randomized bench against a behavioural GPIO model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcs_io_gpio;

    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam int          DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpo;
    logic [7:0] gpi = 8'h00;
    logic       irq;
    logic       chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mcs_io_gpio_if bus ();

    mcs_io_gpio #(
        .BASE_ADDR (BASE),
        .OUT_W     (8),
        .IN_W      (8),
        .DEB_CYCLES(DEB),
        .OUT_RST   (8'hA5)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus),
        .gpo   (gpo),
        .gpi   (gpi),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: register file plus a sliding window of synchronised input samples.
    logic [7:0]  m_out = 8'hA5, m_ien = '0, m_flag = '0, m_in = '0, m_p1 = '0, m_p2 = '0;
    logic        m_irq = 1'b0, m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [7:0]  q_sync[$];

    task automatic model_step();
        logic        hit;
        logic [7:0]  flip;
        logic [31:0] mask, wm;
        logic [5:0]  ofs;
        if (!rst_n) begin
            m_out = 8'hA5; m_ien = '0; m_flag = '0; m_in = '0;
            m_p1 = '0; m_p2 = '0; m_irq = 1'b0; m_ready = 1'b0; m_rdata = '0;
            q_sync.delete();
            return;
        end
        hit  = bus.IO_Addr_Strobe && (bus.IO_Address[31:8] == BASE[31:8]);
        ofs  = bus.IO_Address[7:2];
        mask = {{8{bus.IO_Byte_Enable[3]}}, {8{bus.IO_Byte_Enable[2]}},
                {8{bus.IO_Byte_Enable[1]}}, {8{bus.IO_Byte_Enable[0]}}};
        wm   = bus.IO_Write_Data & mask;
        m_ready = hit;
        m_rdata = '0;
        if (hit && bus.IO_Read_Strobe) begin
            case (ofs)
                6'h00: m_rdata = {24'h0, m_out};
                6'h03: m_rdata = {24'h0, m_in};
                6'h04: m_rdata = {24'h0, m_flag};
                6'h05: m_rdata = {24'h0, m_ien};
                default: m_rdata = '0;
            endcase
        end
        m_irq = |(m_flag & m_ien);
        q_sync.push_back(m_p2);
        if (q_sync.size() > DEB) void'(q_sync.pop_front());
        flip = '0;
        if (q_sync.size() == DEB) begin
            flip = 8'hFF;
            foreach (q_sync[i]) flip &= q_sync[i] ^ m_in;
        end
        m_p2 = m_p1;
        m_p1 = gpi;
        m_in = m_in ^ flip;
        if (hit && bus.IO_Write_Strobe) begin
            case (ofs)
                6'h00: m_out  = (m_out & ~mask[7:0]) | wm[7:0];
                6'h01: m_out  = m_out | wm[7:0];
                6'h02: m_out  = m_out & ~wm[7:0];
                6'h04: m_flag = m_flag & ~wm[7:0];
                6'h05: m_ien  = (m_ien & ~mask[7:0]) | wm[7:0];
                default: ;
            endcase
        end
        m_flag = m_flag | flip;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check_eq("ready", {31'h0, bus.IO_Ready}, {31'h0, m_ready});
            check_eq("rdata", bus.IO_Read_Data, m_rdata);
            check_eq("gpo", {24'h0, gpo}, {24'h0, m_out});
            check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_acc(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [3:0] be, input logic [31:0] wd,
                           output logic [31:0] rdat, output logic rdy);
        bus.IO_Addr_Strobe  = 1'b1;
        bus.IO_Read_Strobe  = rd;
        bus.IO_Write_Strobe = wr;
        bus.IO_Address      = a;
        bus.IO_Byte_Enable  = be;
        bus.IO_Write_Data   = wd;
        @(posedge clk);
        #1;
        bus.IO_Addr_Strobe  = 1'b0;
        bus.IO_Read_Strobe  = 1'b0;
        bus.IO_Write_Strobe = 1'b0;
        rdy  = bus.IO_Ready;
        rdat = bus.IO_Read_Data;
    endtask

    logic [31:0] rd_v;
    logic        rdy_v;

    initial begin
        bus.IO_Addr_Strobe  = 1'b0;
        bus.IO_Read_Strobe  = 1'b0;
        bus.IO_Write_Strobe = 1'b0;
        bus.IO_Address      = '0;
        bus.IO_Byte_Enable  = '0;
        bus.IO_Write_Data   = '0;
        @(posedge clk);
        chk_en = 1'b1;
        idle(2);
        rst_n = 1'b1;
        check_eq("rst_gpo", {24'h0, gpo}, 32'h0000_00A5);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        check_eq("rst_ready", {31'h0, bus.IO_Ready}, 32'h0);

        bus_acc(BASE | 32'h0C, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("rd_in_ready", {31'h0, rdy_v}, 32'h1);
        check_eq("rd_in_data", rd_v, 32'h0);
        idle(1);
        check_eq("ready_single", {31'h0, bus.IO_Ready}, 32'h0);

        bus_acc(BASE, 1'b0, 1'b1, 4'b0001, 32'h0000_003C, rd_v, rdy_v);
        check_eq("wr_data", {24'h0, gpo}, 32'h3C);
        bus_acc(BASE | 32'h04, 1'b0, 1'b1, 4'hF, 32'h0000_00C3, rd_v, rdy_v);
        check_eq("wr_set", {24'h0, gpo}, 32'hFF);
        bus_acc(BASE | 32'h08, 1'b0, 1'b1, 4'hF, 32'h0000_000F, rd_v, rdy_v);
        check_eq("wr_clr", {24'h0, gpo}, 32'hF0);
        check_eq("wr_clr_ready", {31'h0, rdy_v}, 32'h1);

        gpi = 8'h04;
        idle(5);
        bus_acc(BASE | 32'h0C, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("in_early", rd_v, 32'h0);
        bus_acc(BASE | 32'h0C, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("in_latency", rd_v, 32'h04);
        bus_acc(BASE | 32'h10, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("flag_set", rd_v, 32'h04);
        bus_acc(BASE | 32'h14, 1'b0, 1'b1, 4'hF, 32'h04, rd_v, rdy_v);
        check_eq("irq_pre", {31'h0, irq}, 32'h0);
        idle(1);
        check_eq("irq_on", {31'h0, irq}, 32'h1);
        bus_acc(BASE | 32'h10, 1'b0, 1'b1, 4'hF, 32'h04, rd_v, rdy_v);
        check_eq("irq_hold", {31'h0, irq}, 32'h1);
        idle(1);
        check_eq("irq_off", {31'h0, irq}, 32'h0);

        gpi = 8'h05;
        idle(3);
        gpi = 8'h04;
        idle(8);
        bus_acc(BASE | 32'h0C, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("glitch_in", rd_v, 32'h04);
        bus_acc(BASE | 32'h10, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("glitch_flag", rd_v, 32'h0);

        gpi = 8'h24;
        idle(5);
        bus_acc(BASE | 32'h10, 1'b0, 1'b1, 4'hF, 32'h20, rd_v, rdy_v);
        bus_acc(BASE | 32'h10, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("set_wins", rd_v & 32'h20, 32'h20);

        bus_acc(32'hC000_0100, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("miss_ready", {31'h0, rdy_v}, 32'h0);
        bus_acc(BASE | 32'h20, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, rd_v, rdy_v);
        check_eq("hole_ready", {31'h0, rdy_v}, 32'h1);
        check_eq("hole_data", rd_v, 32'h0);

        rst_n = 1'b0;
        bus_acc(BASE, 1'b1, 1'b0, 4'hF, '0, rd_v, rdy_v);
        check_eq("rst_drop_ready", {31'h0, rdy_v}, 32'h0);
        check_eq("rst_mid_gpo", {24'h0, gpo}, 32'hA5);
        rst_n = 1'b1;

        for (int it = 0; it < 600; it++) begin
            logic [31:0] a;
            if ($urandom_range(0, 5) == 0) gpi = gpi ^ (8'h01 << $urandom_range(0, 7));
            if (it == 300) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                a = BASE | 32'($urandom_range(0, 9) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = $urandom;
                bus_acc(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), $urandom, rd_v, rdy_v);
            end
        end
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
